// File: rtl/instruction_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instruction_fetch_ctrl
//
// Purpose: Walks a program counter through instruction memory, captures each
// instruction word into a single-entry output register, and hands it to decode
// over a valid/ready handshake. It supports stalls, branch redirects, and
// stopping at the end of the program.
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap on redirects to a
// target that is not word aligned. This build adds a "misalign" output and a
// TRAP state. When the macro is undefined, the low two bits of the redirect
// target are dropped.
//
// Ports:
//   clk            in   rising-edge clock for all state
//   reset_n        in   synchronous, active-low reset
//   inst_address   out  [63:0] byte address to instruction memory (the PC)
//   instruction    in   [31:0] memory read data for inst_address
//   stall          in   freeze PC and output register
//   branch_taken   in   redirect request; wins over stall/ready/limit
//   branch_target  in   [63:0] redirect byte address
//   fetch_valid    out  output register holds an instruction
//   fetch_ready    in   decode accepts the held instruction this cycle
//   fetch_pc       out  [63:0] address of the held instruction
//   fetch_inst     out  [31:0] held instruction word
//   done           out  PC reached PC_LIMIT and output register is empty
//   fetch_count    out  [31:0] number of accepted instructions (wrapping)
//   misalign       out  (FETCH_MISALIGN_TRAP_EN only) misaligned redirect seen
//   state_dbg      out  [1:0] current FSM state, for observation
//
// Handshake: a transfer happens on every rising edge where fetch_valid and
// fetch_ready are both high. While fetch_valid is high and fetch_ready is low,
// fetch_pc/fetch_inst stay stable. fetch_valid never drops without either a
// transfer or a branch flush.
// ---------------------------------------------------------------------------
module instruction_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] PC_LIMIT = 64'd96
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] inst_address,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [63:0] fetch_pc,
  output logic [31:0] fetch_inst,
  output logic        done,
  output logic [31:0] fetch_count,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic [1:0]  state_dbg
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DONE  = 2'd2,
    TRAP  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t      state;
  logic [63:0] pc;
  logic        transfer;
  logic        at_limit;
  logic        blocked;
  logic [63:0] redirect_pc;

  assign inst_address = pc;
  assign state_dbg    = state;
  assign transfer     = fetch_valid & fetch_ready;
  assign at_limit     = (pc >= PC_LIMIT);
  // The output register is occupied and decode is not taking it this cycle.
  assign blocked      = fetch_valid & ~fetch_ready;
  // Redirects always land on a word boundary in the non-trapping build.
  assign redirect_pc  = branch_target & ~64'd3;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      fetch_pc    <= 64'd0;
      fetch_inst  <= 32'd0;
      fetch_count <= 32'd0;
      done        <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      // A transfer counts even if a redirect flushes in the same cycle.
      if (transfer) begin
        fetch_count <= fetch_count + 32'd1;
      end

`ifdef FETCH_MISALIGN_TRAP_EN
      if (state == TRAP) begin
        // TRAP is sticky until reset; nothing is fetched or presented.
        fetch_valid <= 1'b0;
        done        <= 1'b0;
      end else
`endif
      if (branch_taken) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (branch_target[1:0] != 2'b00) begin
          state       <= TRAP;
          misalign    <= 1'b1;
          fetch_valid <= 1'b0;
          done        <= 1'b0;
        end else begin
          state       <= FETCH;
          pc          <= redirect_pc;
          fetch_valid <= 1'b0;
          done        <= 1'b0;
        end
`else
        state       <= FETCH;
        pc          <= redirect_pc;
        fetch_valid <= 1'b0;
        done        <= 1'b0;
`endif
      end else if (blocked) begin
        // Hold everything until decode takes the instruction.
        state <= HOLD;
      end else if (!stall && !at_limit) begin
        state       <= FETCH;
        fetch_inst  <= instruction;
        fetch_pc    <= pc;
        fetch_valid <= 1'b1;
        pc          <= pc + 64'd4;
        done        <= 1'b0;
      end else begin
        // The register drains (or was already empty) and nothing is captured.
        // It is either a stall or the end of the program.
        fetch_valid <= 1'b0;
        if (at_limit) begin
          state <= DONE;
          done  <= 1'b1;
        end else begin
          state <= FETCH;
          done  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_ctrl
//
// Directed scenarios followed by a randomized run. A behavioural model tracks
// the fetch stream from the rules for redirect, back-pressure, stall and
// program end. The bench also models instruction memory: a small word array.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_ctrl;
  localparam logic [63:0] LIMIT = 64'd96;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        fetch_ready;
  logic [63:0] inst_address;
  logic [31:0] instruction;
  logic        fetch_valid;
  logic [63:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        done;
  logic [31:0] fetch_count;
  logic [1:0]  state_dbg;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  instruction_fetch_ctrl #(.RESET_PC(64'd0), .PC_LIMIT(LIMIT)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .inst_address  (inst_address),
    .instruction   (instruction),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_pc      (fetch_pc),
    .fetch_inst    (fetch_inst),
    .done          (done),
    .fetch_count   (fetch_count),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign      (misalign),
`endif
    .state_dbg     (state_dbg)
  );

  // instruction memory
  logic [31:0] mem [0:31];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a < 64'd128) return mem[a[6:2]];
    return 32'h00000013;
  endfunction

  always_comb instruction = mem_word(inst_address);

  // reference model
  logic [63:0] m_pc;
  logic        m_valid;
  logic [63:0] m_fpc;
  logic [31:0] m_finst;
  logic [31:0] m_count;
  logic        m_done;
  logic        m_trap;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic model_step();
    if (!reset_n) begin
      m_pc = 64'd0; m_valid = 1'b0; m_fpc = 64'd0; m_finst = 32'd0;
      m_count = 32'd0; m_done = 1'b0; m_trap = 1'b0;
      return;
    end
    if (m_valid && fetch_ready) m_count = m_count + 32'd1;
    if (m_trap) begin
      m_valid = 1'b0;
      m_done  = 1'b0;
    end else if (branch_taken) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (branch_target % 64'd4 != 64'd0) begin
        m_trap = 1'b1;
      end else begin
        m_pc = branch_target;
      end
`else
      m_pc = branch_target - (branch_target % 64'd4);
`endif
      m_valid = 1'b0;
      m_done  = 1'b0;
    end else if (m_valid && !fetch_ready) begin
      // decode not taking it: everything waits
    end else if (!stall && m_pc < LIMIT) begin
      m_fpc   = m_pc;
      m_finst = mem_word(m_pc);
      m_valid = 1'b1;
      m_pc    = m_pc + 64'd4;
      m_done  = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_done  = (m_pc >= LIMIT);
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".fetch_valid"},  64'(fetch_valid),  64'(m_valid));
    chk({tag, ".fetch_pc"},     fetch_pc,          m_fpc);
    chk({tag, ".fetch_inst"},   64'(fetch_inst),   64'(m_finst));
    chk({tag, ".fetch_count"},  64'(fetch_count),  64'(m_count));
    chk({tag, ".done"},         64'(done),         64'(m_done));
    chk({tag, ".inst_address"}, inst_address,      m_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk({tag, ".misalign"},     64'(misalign),     64'(m_trap));
`endif
  endtask

  // driver: one clock, model update at the edge, sample 1 ns later
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h00100313;
    mem[8] = 32'h04CA4063;

    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 64'd0; fetch_ready = 1'b0;

    // reset, including reset overriding branch and stall
    tick("reset");
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'd40;
    tick("reset_override");
    chk("reset_pc", inst_address, 64'd0);
    chk("reset_count", 64'(fetch_count), 64'd0);

    // straight-line run to the end of the program
    reset_n = 1'b1; stall = 1'b0; branch_taken = 1'b0; fetch_ready = 1'b1;
    tick("first");
    chk("first_valid", 64'(fetch_valid), 64'd1);
    chk("first_pc", fetch_pc, 64'd0);
    chk("first_inst", 64'(fetch_inst), 64'h00100313);
    for (int i = 0; i < 40 && !m_done; i++) tick("run");
    chk("run_done", 64'(done), 64'd1);
    chk("run_count", 64'(fetch_count), 64'd24);
    chk("run_last_pc", fetch_pc, 64'd92);

    // back-pressure while holding PC 8
    reset_n = 1'b0; tick("reset2");
    reset_n = 1'b1;
    for (int i = 0; i < 20 && !(m_valid && m_fpc == 64'd8); i++) tick("to8");
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("hold8");
      chk("hold_pc", fetch_pc, 64'd8);
      chk("hold_inst", 64'(fetch_inst), 64'(mem[2]));
      chk("hold_addr", inst_address, 64'd12);
    end
    fetch_ready = 1'b1;
    tick("release");
    chk("release_pc", fetch_pc, 64'd12);

    // stall and branch together: branch wins
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'd32;
    tick("stall_branch");
    chk("flush_valid", 64'(fetch_valid), 64'd0);
    stall = 1'b0; branch_taken = 1'b0;
    tick("after_branch");
    chk("br32_pc", fetch_pc, 64'd32);
    chk("br32_inst", 64'(fetch_inst), 64'h04CA4063);

    // run out, then leave DONE with a branch
    for (int i = 0; i < 40 && !m_done; i++) tick("run2");
    chk("run2_done", 64'(done), 64'd1);
    tick("done_idle");
    chk("done_pc_hold", inst_address, 64'd96);
    branch_taken = 1'b1; branch_target = 64'd36;
    tick("done_branch");
    chk("done_cleared", 64'(done), 64'd0);
    branch_taken = 1'b0;
    tick("refetch36");
    chk("br36_pc", fetch_pc, 64'd36);

    // reset while holding PC 60
    for (int i = 0; i < 20 && !(m_valid && m_fpc == 64'd60); i++) tick("to60");
    fetch_ready = 1'b0;
    tick("hold60");
    chk("hold60_pc", fetch_pc, 64'd60);
    reset_n = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 64'd8;
    tick("reset_hold");
    chk("rh_valid", 64'(fetch_valid), 64'd0);
    chk("rh_pc", fetch_pc, 64'd0);
    reset_n = 1'b1; stall = 1'b0; branch_taken = 1'b0; fetch_ready = 1'b1;
    tick("refetch0");
    chk("refetch0_pc", fetch_pc, 64'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      fetch_ready   = ($urandom_range(0, 2) != 0);
      branch_taken  = ($urandom_range(0, 15) == 0);
      branch_target = 64'($urandom_range(0, 30)) * 64'd4;
`ifndef FETCH_MISALIGN_TRAP_EN
      branch_target = branch_target + 64'($urandom_range(0, 3));
`endif
      reset_n       = ($urandom_range(0, 99) != 0);
      tick("rand");
    end

    // misaligned redirect
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; fetch_ready = 1'b1;
    tick("reset3");
    reset_n = 1'b1;
    tick("pre_mis");
    tick("pre_mis");
    branch_taken = 1'b1; branch_target = 64'h22;
    tick("mis_branch");
    branch_taken = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) tick("trap");
    chk("trap_misalign", 64'(misalign), 64'd1);
    chk("trap_valid", 64'(fetch_valid), 64'd0);
    branch_taken = 1'b1; branch_target = 64'd16;
    tick("trap_branch");
    branch_taken = 1'b0;
    tick("trap_stays");
    chk("trap_stays_valid", 64'(fetch_valid), 64'd0);
`else
    tick("mis_refetch");
    chk("mis_pc", fetch_pc, 64'h20);
    chk("mis_valid", 64'(fetch_valid), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_ctrl.md
INSTRUCTION_FETCH_CTRL -- requirements
Module: instruction_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 0: byte address fetched first after reset.
REQ-002 Parameter PC_LIMIT, default 96: first byte address past the program; fetch stops there.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 Port inst_address, output, 64: byte address driven to instruction memory; equals the internal PC.
REQ-006 Port instruction, input, 32: instruction memory read data, combinational from inst_address.
REQ-007 Port stall, input, 1: hold fetch; PC and output register frozen.
REQ-008 Port branch_taken, input, 1: redirect request from execute.
REQ-009 Port branch_target, input, 64: redirect byte address.
REQ-010 Port fetch_valid, output, 1: fetch_pc and fetch_inst hold a valid instruction.
REQ-011 Port fetch_ready, input, 1: decode accepts the instruction this cycle.
REQ-012 Port fetch_pc, output, 64: address of the held instruction.
REQ-013 Port fetch_inst, output, 32: held instruction word.
REQ-014 Port done, output, 1: PC has reached PC_LIMIT and the output register is empty.
REQ-015 Port fetch_count, output, 32: number of instructions accepted (fetch_valid and fetch_ready both high).

Function
REQ-016 State machine SHALL have exactly these states: FETCH, HOLD, DONE (TRAP only per REQ-034).
REQ-017 Transfer SHALL occur on every cycle with fetch_valid=1 and fetch_ready=1; fetch_count SHALL increment by 1 on each transfer and wrap from 0xFFFFFFFF to 0.
REQ-018 In FETCH with stall=0, branch_taken=0, PC<PC_LIMIT and (fetch_valid=0 or fetch_ready=1): on the clock edge, fetch_inst<=instruction, fetch_pc<=PC, fetch_valid<=1, PC<=PC+4; latency from address to fetch_valid SHALL be one cycle.
REQ-019 With fetch_valid=1 and fetch_ready=0, state SHALL be HOLD; fetch_pc, fetch_inst and PC SHALL be unchanged until a transfer occurs, then return to FETCH.
REQ-020 With stall=1 and branch_taken=0: PC, fetch_pc, fetch_inst and fetch_valid SHALL hold; no capture; fetch_count SHALL still increment on a transfer, and fetch_valid SHALL clear after that transfer.
REQ-021 branch_taken=1 SHALL have priority over stall, fetch_ready and PC limit: PC<=branch_target, fetch_valid<=0 (flush), no capture that cycle, next state FETCH from any state except TRAP.
REQ-022 A transfer in the same cycle as branch_taken=1 SHALL still count in fetch_count.
REQ-023 When PC>=PC_LIMIT and fetch_valid=0 and branch_taken=0, next state SHALL be DONE; done=1 only in DONE.
REQ-024 In DONE, PC SHALL hold and fetch_valid SHALL stay 0 until branch_taken=1.
REQ-025 PC arithmetic SHALL be 64-bit unsigned; PC+4 wraps modulo 2^64.
REQ-026 inst_address SHALL equal PC combinationally at all times, including during stall and HOLD.

Reset
REQ-027 reset_n=0 at a rising edge SHALL set PC=RESET_PC, state=FETCH, fetch_valid=0, fetch_pc=0, fetch_inst=0, fetch_count=0, done=0.
REQ-028 Reset SHALL override all inputs, including branch_taken and stall, mid-operation from any state.
REQ-029 The first capture after reset SHALL occur on the first rising edge with reset_n=1.
REQ-030 Outputs before the first clock edge are undefined; benches SHALL not check them.

Configuration
REQ-031 Macro FETCH_MISALIGN_TRAP_EN SHALL select misaligned-redirect trapping.
REQ-032 When defined: an extra output misalign, 1 bit, SHALL exist, reset 0.
REQ-033 When defined: branch_taken=1 with branch_target[1:0]!=0 SHALL enter TRAP, set misalign=1 and leave PC unchanged.
REQ-034 When defined: TRAP SHALL hold fetch_valid=0 and done=0 and exit only via reset.
REQ-035 When undefined: there SHALL be no misalign port and no TRAP state, and branch_target SHALL be used with bits [1:0] forced to 0.

Verification
REQ-036 Reset, then fetch_ready=1 constantly -> fetch_pc sequence 0,4,8,..,92; word at PC 0 = 0x00100313; done=1 after the PC-92 transfer; fetch_count=24.
REQ-037 fetch_ready=0 for 3 cycles while fetch_pc=8 -> fetch_pc/fetch_inst stable, inst_address=12 throughout; then fetch_pc=12 one cycle after fetch_ready rises.
REQ-038 stall=1 and branch_taken=1 together with target 32 -> fetch_valid=0 next cycle; fetch_pc=32 and fetch_inst=0x04CA4063 the cycle after.
REQ-039 In DONE, branch_taken=1 with target 36 -> state FETCH, done=0, fetch_pc=36 two cycles later.
REQ-040 reset_n=0 while in HOLD at PC 60 -> all outputs at reset values, then refetch from PC 0.
REQ-041 With FETCH_MISALIGN_TRAP_EN: branch to 0x22 -> misalign=1, fetch_valid=0 until reset; without it: fetch_pc=0x20.
